// File: rtl/fp_int_pkg.sv
// Shared definitions for the FP-INT MAC: FP16 format constants, the default
// accumulator binary-point offset and the output converter state encoding.
package fp_int_pkg;

    localparam int unsigned FP16_EXP_W   = 5;
    localparam int unsigned FP16_MAN_W   = 10;
    localparam int unsigned FP16_BIAS    = 15;
    localparam int unsigned FRAC_DEFAULT = 20;

    localparam logic [14:0] FP16_MAX_FINITE = 15'h7BFF;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StNorm,
        StPack,
        StDone
    } cvt_state_e;

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational rounding, range checks and FP16 packing for the output
// converter. Build option: define FP_ACC_RNE_EN for round-to-nearest-even,
// otherwise the mantissa is truncated and no rounding logic exists.
module fp16_round_pack
    import fp_int_pkg::*;
#(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned EXP_W = FP16_EXP_W,
    parameter int unsigned MAN_W = FP16_MAN_W
) (
    input  logic              sign,
    input  logic signed [7:0] e,
    input  logic [ACC_W-1:0]  mag,
    input  logic              zero,
    output logic [15:0]       fp_out,
    output logic              ovf,
    output logic              unf
);

    // Largest biased exponent of a finite number (all-ones is Inf/NaN).
    localparam logic signed [7:0] E_MAX = 8'((1 << EXP_W) - 2);

    logic [MAN_W-1:0]  m_raw;
    logic [MAN_W-1:0]  m_fin;
    logic signed [7:0] e_fin;

    // mag is normalised: bit ACC_W-1 is the hidden one and is not stored.
    assign m_raw = mag[ACC_W-2 -: MAN_W];

    logic unused_msb;
    assign unused_msb = mag[ACC_W-1];

`ifdef FP_ACC_RNE_EN
    logic           g;
    logic           st;
    logic           inc;
    logic [MAN_W:0] m_sum;

    assign g     = mag[ACC_W-2-MAN_W];
    assign st    = |mag[ACC_W-3-MAN_W:0];
    assign inc   = g & (st | m_raw[0]);
    assign m_sum = {1'b0, m_raw} + (MAN_W+1)'(inc);
    // A carry out leaves the low mantissa bits zero; bump the exponent.
    assign m_fin = m_sum[MAN_W-1:0];
    assign e_fin = e + 8'(m_sum[MAN_W]);
`else
    logic unused_low;
    assign unused_low = ^mag[ACC_W-2-MAN_W:0];
    assign m_fin      = m_raw;
    assign e_fin      = e;
`endif

    // Select zero, saturated, flushed or normal encoding.
    always_comb begin
        fp_out = 16'h0000;
        ovf    = 1'b0;
        unf    = 1'b0;
        if (zero) begin
            fp_out = 16'h0000;
        end else if (e_fin > E_MAX) begin
            fp_out = {sign, FP16_MAX_FINITE};
            ovf    = 1'b1;
        end else if (e_fin <= 8'sd0) begin
            fp_out = {sign, 15'h0000};
            unf    = 1'b1;
        end else begin
            fp_out = {sign, e_fin[EXP_W-1:0], m_fin};
        end
    end

endmodule

// File: rtl/fp_acc_to_fp16.sv
// Output converter: signed fixed-point accumulator word plus block exponent to
// IEEE FP16. Normalises iteratively, one left shift per cycle.
// Build option: FP_ACC_RNE_EN selects round-to-nearest-even in fp16_round_pack.
module fp_acc_to_fp16
    import fp_int_pkg::*;
#(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned EXP_W = FP16_EXP_W,
    parameter int unsigned MAN_W = FP16_MAN_W,
    parameter int unsigned FRAC  = FRAC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [EXP_W-1:0] exp_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      fp_out,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned SC_W = $clog2(ACC_W);

    cvt_state_e state_q, state_d;

    logic [ACC_W-1:0] acc_q;
    logic [EXP_W-1:0] exp_q;
    logic [ACC_W-1:0] mag_q;
    logic [SC_W-1:0]  sc_q;
    logic             sign_q;
    logic             zero_q;
    logic [15:0]      fp_q;
    logic             ovf_q;
    logic             unf_q;

    logic [ACC_W-1:0]  acc_abs;
    logic signed [7:0] e_pack;
    logic [15:0]       pk_fp;
    logic              pk_ovf;
    logic              pk_unf;

    // Most negative input maps to its own bit pattern, which is the correct
    // unsigned magnitude.
    assign acc_abs = acc_q[ACC_W-1] ? (~acc_q + ACC_W'(1)) : acc_q;

    // Biased exponent: leading-one position plus block exponent minus offset.
    assign e_pack = 8'(ACC_W - 1) - 8'(sc_q) + 8'(exp_q) - 8'(FRAC);

    fp16_round_pack #(
        .ACC_W (ACC_W),
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign   (sign_q),
        .e      (e_pack),
        .mag    (mag_q),
        .zero   (zero_q),
        .fp_out (pk_fp),
        .ovf    (pk_ovf),
        .unf    (pk_unf)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = StLoad;
            StLoad: begin
                if (acc_abs == '0 || acc_abs[ACC_W-1]) begin
                    state_d = StPack;
                end else begin
                    state_d = StNorm;
                end
            end
            // Look at the bit that becomes the MSB after this cycle's shift.
            StNorm: if (mag_q[ACC_W-2]) state_d = StPack;
            StPack: state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: capture, magnitude/sign, shift-normalise, result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            exp_q  <= '0;
            mag_q  <= '0;
            sc_q   <= '0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            fp_q   <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        acc_q <= acc_in;
                        exp_q <= exp_in;
                    end
                end
                StLoad: begin
                    sign_q <= acc_q[ACC_W-1];
                    mag_q  <= acc_abs;
                    sc_q   <= '0;
                    zero_q <= (acc_abs == '0);
                end
                StNorm: begin
                    mag_q <= mag_q << 1;
                    sc_q  <= sc_q + SC_W'(1);
                end
                StPack: begin
                    fp_q  <= pk_fp;
                    ovf_q <= pk_ovf;
                    unf_q <= pk_unf;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign fp_out    = fp_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_fp_acc_to_fp16.sv
// Self-checking bench for fp_acc_to_fp16: directed cases, hold/ignore and
// mid-conversion reset, then random words against a value-level FP16 model.
module tb_fp_acc_to_fp16;
    import fp_int_pkg::*;

    localparam int FRAC = FRAC_DEFAULT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] acc_in = '0;
    logic [4:0]  exp_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] fp_out;
    logic        ovf;
    logic        unf;

    int n_cmp = 0;
    int n_err = 0;

    fp_acc_to_fp16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_in    (acc_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_out    (fp_out),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Value-level model: |acc| = 1.f * 2^p, so the FP16 biased exponent is
    // p + exp - bias - FRAC + bias. Remainder bits decide rounding.
    function automatic void ref_conv(input logic [31:0] acc, input logic [4:0] ex,
                                     output logic [15:0] fp, output logic o, output logic u,
                                     output int lat);
        longint mag, m, rem, half;
        int p, e, sh;
        logic s;
        s   = acc[31];
        mag = s ? (64'h1_0000_0000 - longint'(acc)) : longint'(acc);
        fp = 16'h0; o = 1'b0; u = 1'b0;
        if (mag == 0) begin
            lat = 3;
            return;
        end
        p = 0;
        for (int i = 0; i < 32; i++) if (((mag >> i) & 1) == 1) p = i;
        lat = 3 + (31 - p);
        e = (p + int'(ex) - int'(FP16_BIAS) - FRAC) + int'(FP16_BIAS);
        if (p >= 10) begin
            sh  = p - 10;
            m   = (mag >> sh) & 1023;
            rem = mag & ((64'd1 << sh) - 1);
            half = (sh > 0) ? (64'd1 << (sh - 1)) : 0;
`ifdef FP_ACC_RNE_EN
            if (sh > 0 && (rem > half || (rem == half && (m % 2) == 1))) m = m + 1;
`else
            if (rem > half) m = m; // truncation keeps m
`endif
        end else begin
            m = (mag << (10 - p)) & 1023;
        end
        if (m == 1024) begin
            m = 0;
            e = e + 1;
        end
        if (e > 30) begin
            fp = {s, 15'h7BFF};
            o  = 1'b1;
        end else if (e <= 0) begin
            fp = {s, 15'h0};
            u  = 1'b1;
        end else begin
            fp = {s, 5'(e), 10'(m)};
        end
    endfunction

    // One conversion; hold > 0 keeps out_ready low that many cycles while
    // checking stability and offering another word that must be ignored.
    task automatic run_conv(input logic [31:0] acc, input logic [4:0] ex, input int hold,
                            output logic [15:0] fp, output logic o, output logic u,
                            output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) check_eq("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1; acc_in = acc; exp_in = ex;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("busy_in_ready", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) check_eq("out_valid_timeout", 32'(out_valid), 32'd1);
        fp = fp_out; o = ovf; u = unf;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; acc_in = 32'h1234_5678; exp_in = 5'd25;
            @(posedge clk); #1;
            check_eq("hold_fp", 32'(fp_out), 32'(fp));
            check_eq("hold_valid_ready", {30'd0, out_valid, in_ready}, 32'b10);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("released", {30'd0, out_valid, in_ready}, 32'b01);
        if (hold > 0) begin
            repeat (3) @(posedge clk);
            #1;
            check_eq("ignored_word", {30'd0, out_valid, in_ready}, 32'b01);
        end
    endtask

    logic [31:0] d_acc [7] = '{32'h1, 32'hFFFF_FFFD, 32'hFFF, 32'h7FFF_FFFF, 32'h1, 32'h0,
                               32'h8000_0000};
    logic [4:0]  d_exp [7] = '{5'd30, 5'd20, 5'd20, 5'd31, 5'd19, 5'd20, 5'd31};
`ifdef FP_ACC_RNE_EN
    logic [15:0] d_fp  [7] = '{16'h2800, 16'h8600, 16'h3000, 16'h7BFF, 16'h0, 16'h0, 16'hFBFF};
`else
    logic [15:0] d_fp  [7] = '{16'h2800, 16'h8600, 16'h2FFF, 16'h7BFF, 16'h0, 16'h0, 16'hFBFF};
`endif
    logic        d_ovf [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        d_unf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          d_lat [7] = '{34, 33, 23, 4, 34, 3, 3};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fp, r_fp;
        logic o, u, r_o, r_u;
        int lat, r_lat;
        logic [31:0] acc;
        logic [4:0] ex;

        #12;
        check_eq("rst_outputs", {27'd0, in_ready, out_valid, ovf, unf, 1'b0}, 32'b10000);
        check_eq("rst_fp", 32'(fp_out), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_conv(d_acc[i], d_exp[i], 0, fp, o, u, lat);
            check_eq($sformatf("dir%0d_fp", i), 32'(fp), 32'(d_fp[i]));
            check_eq($sformatf("dir%0d_ovf_unf", i), {30'd0, o, u}, {30'd0, d_ovf[i], d_unf[i]});
            check_eq($sformatf("dir%0d_lat", i), 32'(lat), 32'(d_lat[i]));
        end

        // Zero result held with out_ready low; a second word is offered.
        run_conv(32'h0, 5'd15, 5, fp, o, u, lat);
        check_eq("hold_zero_fp", 32'(fp), 32'h0);
        check_eq("hold_zero_lat", 32'(lat), 32'd3);

        // Reset ten cycles into normalisation.
        in_valid = 1'b1; acc_in = 32'h1; exp_in = 5'd30;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_state", {29'd0, in_ready, out_valid, ovf | unf}, 32'b100);
        check_eq("midrst_fp", 32'(fp_out), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_conv(32'h1, 5'd30, 0, fp, o, u, lat);
        check_eq("post_rst_fp", 32'(fp), 32'h2800);
        check_eq("post_rst_lat", 32'(lat), 32'd34);

        for (int i = 0; i < 300; i++) begin
            acc = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) acc = -acc;
            ex = 5'($urandom_range(0, 31));
            ref_conv(acc, ex, r_fp, r_o, r_u, r_lat);
            run_conv(acc, ex, 0, fp, o, u, lat);
            check_eq($sformatf("rnd%0d_fp acc=%h exp=%0d", i, acc, ex), 32'(fp), 32'(r_fp));
            check_eq($sformatf("rnd%0d_flags", i), {30'd0, o, u}, {30'd0, r_o, r_u});
            check_eq($sformatf("rnd%0d_lat", i), 32'(lat), 32'(r_lat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
